graph_scheduler: RTL
====================

Name: graph_scheduler

Overview:
- Frame-level controller and per-pixel layer arbiter for the VGA graphics path.
- Per pixel, selects the final rgb from text, sprite, ball and background sources by fixed priority, and registers it on the pixel tick.
- Per frame, sequences the background scene. Runs the IDLE/SCROLL/PAUSE/FLASH state machine and generates the horizontal scroll offset that is added to pixel_x before the background generator.

Parameters:
FRAMES_PER_STEP, 4, refr_tick count between scroll steps (range 1..255)
SCROLL_STEP, 8, pixels added to bg_offset per step (range 1..639)
FLASH_FRAMES, 30, frames the inverted-colour flash lasts (range 1..255)
H_VISIBLE, 640, visible width; bg_offset wraps modulo this

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pixel_tick  in  1  one-cycle pixel enable (25 MHz rate)
refr_tick  in  1  one-cycle pulse at the start of vertical blanking
video_on  in  1  visible-area flag from the sync generator
start  in  1  one-cycle pulse: leave IDLE
pause  in  1  one-cycle pulse: toggle PAUSE
flash_req  in  1  one-cycle pulse: begin flash
text_on, sprite_on, ball_on  in  1 each  layer hit flags for the current pixel
text_rgb, sprite_rgb, ball_rgb, bg_rgb  in  3 each  layer colours
rgb  out  3  registered final colour
bg_offset  out  10  scroll offset for the background x coordinate
state  out  2  00 IDLE, 01 SCROLL, 10 PAUSE, 11 FLASH

Behaviour:
- Reset (async, active-high): state=IDLE; rgb=000; bg_offset=0; frame_cnt=0; flash_cnt=0.
- Pixel path: rgb updates only on clk edges where pixel_tick=1, so latency is 1 pixel_tick. Otherwise rgb holds.
  - video_on=0 -> rgb=000.
  - Otherwise priority is text_on > sprite_on > ball_on > bg_rgb.
  - In FLASH the selected colour is bitwise inverted. Blanking stays 000.
- frame_cnt (8 bit):
  - Increments on refr_tick only in SCROLL.
  - At FRAMES_PER_STEP-1 it wraps to 0 and performs a scroll step.
  - Cleared on entry to IDLE. Held in PAUSE and FLASH.
- Scroll step: bg_offset <= bg_offset+SCROLL_STEP, minus H_VISIBLE if the sum is >= H_VISIBLE. It never reaches 640. Compute the sum at 11-bit width.
- FSM transitions are registered and take effect on the next clk:
  - IDLE: start -> SCROLL. pause and flash_req are ignored. bg_offset is forced to 0.
  - SCROLL: flash_req -> FLASH, and flash_cnt is loaded with 0. Otherwise pause -> PAUSE.
  - PAUSE: pause -> SCROLL. flash_req -> FLASH. bg_offset is frozen.
  - FLASH: flash_cnt increments on refr_tick. When flash_cnt=FLASH_FRAMES-1 and refr_tick=1, go to SCROLL.
    - flash_req in FLASH restarts flash_cnt at 0.
    - pause in FLASH is ignored.
    - bg_offset is frozen.
  - start outside IDLE is ignored.
- Simultaneous events:
  - flash_req and pause in the same cycle: flash_req wins.
  - A refr_tick arriving in the same cycle as a transition is evaluated under the old state. Example: a scroll step still occurs when SCROLL->PAUSE and refr_tick coincide.
- Reset asserted mid-FLASH or mid-scroll returns everything to the reset values immediately. No partial frame completes.

Decomposition:
- Shared header graph_defs.vh holds:
  - Colour constants NEGRO..BLANCO (3'b000..3'b111).
  - State encodings ST_IDLE/ST_SCROLL/ST_PAUSE/ST_FLASH.
  - H_VISIBLE.
- One sub-module, frame_counter: a parameterised modulo-N counter with enable, clear and wrap-pulse output. It is instantiated twice, for frame_cnt (N=FRAMES_PER_STEP) and flash_cnt (N=FLASH_FRAMES).
- The layer mux and FSM stay in graph_scheduler.

Test Plan:
- Reset mid-operation: drive SCROLL with bg_offset=24, assert reset -> same cycle state=00, bg_offset=0, rgb=000. Release reset, send no start, give 10 refr_ticks -> bg_offset stays 0.
- Scroll timing: start, then 4 refr_ticks (defaults) -> bg_offset=8. Further ticks to bg_offset=632, then 4 more -> bg_offset=0 (wrap). Repeat with SCROLL_STEP=100 from 600 -> 60.
- Priority and latency: video_on=1, all *_on=1, text_rgb=001, sprite_rgb=010 -> rgb=001 one pixel_tick later. With text_on=0 -> 010. With all *_on=0 and bg_rgb=110 -> 110. With video_on=0 -> 000. With pixel_tick low, rgb holds.
- Pause: in SCROLL send pause, then 8 refr_ticks -> state=10, bg_offset unchanged. Send pause again -> state=01 and scrolling resumes from the held frame_cnt.
- Flash: bg_rgb=010, send flash_req -> state=11, rgb=101. After 30 refr_ticks -> state=01, rgb=010. A flash_req at tick 20 extends FLASH to tick 50. pause+flash_req together in SCROLL -> state=11.
- Ignored inputs: in IDLE send flash_req and pause -> state stays 00. In SCROLL send start -> no change.

Source files
------------

// File: rtl/graph_scheduler_pkg.sv
// Shared definitions for the graphics scheduler: colour constants, FSM
// state encoding and the visible line width used for scroll wrapping.
package graph_scheduler_pkg;

    localparam logic [2:0] NEGRO    = 3'b000;
    localparam logic [2:0] AZUL     = 3'b001;
    localparam logic [2:0] VERDE    = 3'b010;
    localparam logic [2:0] CIAN     = 3'b011;
    localparam logic [2:0] ROJO     = 3'b100;
    localparam logic [2:0] MAGENTA  = 3'b101;
    localparam logic [2:0] AMARILLO = 3'b110;
    localparam logic [2:0] BLANCO   = 3'b111;

    localparam int H_VISIBLE = 640;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SCROLL = 2'b01,
        ST_PAUSE  = 2'b10,
        ST_FLASH  = 2'b11
    } sched_state_t;

endpackage

// File: rtl/graph_scheduler_frame_counter.sv
// Modulo-N event counter with synchronous clear; wrap is high on the
// enabled cycle in which the count rolls from N-1 back to 0.
module frame_counter #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    logic [7:0] count;

    assign wrap = en && (count == 8'(N - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= 8'd0;
        else if (clr || wrap)
            count <= 8'd0;
        else if (en)
            count <= count + 8'd1;
    end

endmodule

// File: rtl/graph_scheduler.sv
// Frame sequencer (IDLE/SCROLL/PAUSE/FLASH) and per-pixel layer arbiter
// for the VGA path; produces the registered rgb and the background scroll.
module graph_scheduler
    import graph_scheduler_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 4,
    parameter int SCROLL_STEP     = 8,
    parameter int FLASH_FRAMES    = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixel_tick,
    input  logic       refr_tick,
    input  logic       video_on,
    input  logic       start,
    input  logic       pause,
    input  logic       flash_req,
    input  logic       text_on,
    input  logic       sprite_on,
    input  logic       ball_on,
    input  logic [2:0] text_rgb,
    input  logic [2:0] sprite_rgb,
    input  logic [2:0] ball_rgb,
    input  logic [2:0] bg_rgb,
    output logic [2:0] rgb,
    output logic [9:0] bg_offset,
    output logic [1:0] state
);

    sched_state_t st, st_next;
    logic         step_wrap, flash_wrap;
    logic [10:0]  offset_sum;
    logic [2:0]   layer_rgb;

    assign state = st;

    frame_counter #(.N(FRAMES_PER_STEP)) u_frame_cnt (
        .clk   (clk),
        .reset (reset),
        .en    ((st == ST_SCROLL) && refr_tick),
        .clr   (st == ST_IDLE),
        .wrap  (step_wrap)
    );

    // A flash request outside IDLE always restarts the flash from frame 0.
    frame_counter #(.N(FLASH_FRAMES)) u_flash_cnt (
        .clk   (clk),
        .reset (reset),
        .en    ((st == ST_FLASH) && refr_tick),
        .clr   ((st != ST_IDLE) && flash_req),
        .wrap  (flash_wrap)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        st_next = st;
        unique case (st)
            ST_IDLE:   if (start) st_next = ST_SCROLL;
            ST_SCROLL: if (flash_req) st_next = ST_FLASH;
                       else if (pause) st_next = ST_PAUSE;
            ST_PAUSE:  if (flash_req) st_next = ST_FLASH;
                       else if (pause) st_next = ST_SCROLL;
            ST_FLASH:  if (!flash_req && flash_wrap) st_next = ST_SCROLL;
            default:   st_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            st <= ST_IDLE;
        else
            st <= st_next;
    end

    assign offset_sum = {1'b0, bg_offset} + 11'(SCROLL_STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bg_offset <= 10'd0;
        else if (st == ST_IDLE)
            bg_offset <= 10'd0;
        else if ((st == ST_SCROLL) && step_wrap)
            bg_offset <= (offset_sum >= 11'(H_VISIBLE))
                       ? 10'(offset_sum - 11'(H_VISIBLE))
                       : offset_sum[9:0];
    end

    always_comb begin
        layer_rgb = bg_rgb;
        if (text_on)
            layer_rgb = text_rgb;
        else if (sprite_on)
            layer_rgb = sprite_rgb;
        else if (ball_on)
            layer_rgb = ball_rgb;
    end

    // Blanking wins over the flash inversion so sync intervals stay black.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rgb <= NEGRO;
        else if (pixel_tick)
            rgb <= !video_on ? NEGRO
                 : (st == ST_FLASH) ? ~layer_rgb
                 : layer_rgb;
    end

endmodule
